// File: rtl/uart_link_ctrl.sv
// uart_link_ctrl: two-byte framed link over a byte-wide UART FIFO pair.
//
// A frame is a header byte (TYPE_CHAR or TYPE_OVER) followed by one payload byte.
// Transmit: a held character request or a pulsed game-over request is latched,
//   then written as header and payload, stalling while the TX FIFO is full.
// Receive: every available RX byte is popped and parsed. Character frames update
//   rx_char, game-over frames set a sticky flag, and bad headers are dropped.
//
// Ports
//   clk_i, rst_ni        clock, asynchronous active-low reset
//   char_req_i/_data_i   character send request (level) and payload
//   char_ack_o           pulse: request accepted, payload latched
//   over_req_i           pulse: local game over
//   tx_full_i            TX FIFO full
//   wr_uart_o, w_data_o  TX FIFO write strobe and byte
//   rx_empty_i, r_data_i RX FIFO empty flag and show-ahead head byte
//   rd_uart_o            RX FIFO pop strobe
//   rx_char_o            last received character payload
//   rx_char_valid_o      pulse: rx_char_o updated
//   remote_over_o        sticky: peer sent game over
//   frame_err_o          pulse: unknown header byte discarded
//   tx_busy_o            transmitter not idle
module uart_link_ctrl #(
  parameter logic [7:0] TYPE_CHAR    = 8'hC1,
  parameter logic [7:0] TYPE_OVER    = 8'hF0,
  parameter logic [7:0] OVER_PAYLOAD = 8'h00
) (
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic       char_req_i,
  input  logic [7:0] char_data_i,
  output logic       char_ack_o,
  input  logic       over_req_i,
  input  logic       tx_full_i,
  output logic       wr_uart_o,
  output logic [7:0] w_data_o,
  input  logic       rx_empty_i,
  input  logic [7:0] r_data_i,
  output logic       rd_uart_o,
  output logic [7:0] rx_char_o,
  output logic       rx_char_valid_o,
  output logic       remote_over_o,
  output logic       frame_err_o,
  output logic       tx_busy_o
);

  typedef enum logic [1:0] {TIdle, THdr, TPay} tx_state_e;
  typedef enum logic {RType, RPay} rx_state_e;

  // ---------------- Transmit ----------------
  tx_state_e  tx_state_q, tx_state_d;
  logic       over_pend_q, over_pend_d;
  logic [7:0] hdr_q, hdr_d;
  logic [7:0] pay_q, pay_d;
  logic       char_ack_q, char_ack_d;

  always_comb begin
    tx_state_d  = tx_state_q;
    over_pend_d = over_pend_q | over_req_i;
    hdr_d       = hdr_q;
    pay_d       = pay_q;
    char_ack_d  = 1'b0;
    wr_uart_o   = 1'b0;
    w_data_o    = 8'h00;
    unique case (tx_state_q)
      TIdle: begin
        if (over_pend_q) begin
          // A game over pulse arriving as the pending one launches merges into it.
          hdr_d       = TYPE_OVER;
          pay_d       = OVER_PAYLOAD;
          over_pend_d = 1'b0;
          tx_state_d  = THdr;
        end else if (char_req_i) begin
          hdr_d      = TYPE_CHAR;
          pay_d      = char_data_i;
          char_ack_d = 1'b1;
          tx_state_d = THdr;
        end
      end
      THdr: begin
        wr_uart_o = ~tx_full_i;
        w_data_o  = hdr_q;
        if (!tx_full_i) tx_state_d = TPay;
      end
      TPay: begin
        wr_uart_o = ~tx_full_i;
        w_data_o  = pay_q;
        if (!tx_full_i) tx_state_d = TIdle;
      end
      default: tx_state_d = TIdle;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      tx_state_q  <= TIdle;
      over_pend_q <= 1'b0;
      hdr_q       <= 8'h00;
      pay_q       <= 8'h00;
      char_ack_q  <= 1'b0;
    end else begin
      tx_state_q  <= tx_state_d;
      over_pend_q <= over_pend_d;
      hdr_q       <= hdr_d;
      pay_q       <= pay_d;
      char_ack_q  <= char_ack_d;
    end
  end

  assign char_ack_o = char_ack_q;
  assign tx_busy_o  = (tx_state_q != TIdle);

  // ---------------- Receive ----------------
  rx_state_e  rx_state_q, rx_state_d;
  logic       kind_over_q, kind_over_d;
  logic [7:0] rx_char_q, rx_char_d;
  logic       rx_valid_q, rx_valid_d;
  logic       remote_over_q, remote_over_d;
  logic       frame_err_q, frame_err_d;
  logic       pop;

  // Pop whatever is available; held low while reset is asserted.
  assign pop       = rst_ni & ~rx_empty_i;
  assign rd_uart_o = pop;

  always_comb begin
    rx_state_d    = rx_state_q;
    kind_over_d   = kind_over_q;
    rx_char_d     = rx_char_q;
    rx_valid_d    = 1'b0;
    remote_over_d = remote_over_q;
    frame_err_d   = 1'b0;
    if (pop) begin
      unique case (rx_state_q)
        RType: begin
          if (r_data_i == TYPE_CHAR) begin
            kind_over_d = 1'b0;
            rx_state_d  = RPay;
          end else if (r_data_i == TYPE_OVER) begin
            kind_over_d = 1'b1;
            rx_state_d  = RPay;
          end else begin
            // Stay in RType so the next byte is tried as a header.
            frame_err_d = 1'b1;
          end
        end
        RPay: begin
          if (kind_over_q) begin
            remote_over_d = 1'b1;
          end else begin
            rx_char_d  = r_data_i;
            rx_valid_d = 1'b1;
          end
          rx_state_d = RType;
        end
        default: rx_state_d = RType;
      endcase
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rx_state_q    <= RType;
      kind_over_q   <= 1'b0;
      rx_char_q     <= 8'h00;
      rx_valid_q    <= 1'b0;
      remote_over_q <= 1'b0;
      frame_err_q   <= 1'b0;
    end else begin
      rx_state_q    <= rx_state_d;
      kind_over_q   <= kind_over_d;
      rx_char_q     <= rx_char_d;
      rx_valid_q    <= rx_valid_d;
      remote_over_q <= remote_over_d;
      frame_err_q   <= frame_err_d;
    end
  end

  assign rx_char_o       = rx_char_q;
  assign rx_char_valid_o = rx_valid_q;
  assign remote_over_o   = remote_over_q;
  assign frame_err_o     = frame_err_q;

endmodule

// File: tb/tb_uart_link_ctrl.sv
// Scoreboard bench for uart_link_ctrl: drivers push expected TX bytes and RX
// events into queues; a monitor pops and compares whenever the DUT emits them.
module tb_uart_link_ctrl;
  localparam logic [7:0] TC = 8'hC1;
  localparam logic [7:0] TO = 8'hF0;
  localparam logic [7:0] OP = 8'h00;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       char_req, over_req, tx_full, rx_empty;
  logic [7:0] char_data, r_data;
  logic       char_ack, wr_uart, rd_uart, rx_char_valid, remote_over, frame_err, tx_busy;
  logic [7:0] w_data, rx_char;
  logic       full_rand, full_force, full_rnd_bit;

  always #5 clk = ~clk;
  always @(posedge clk) full_rnd_bit <= ($urandom_range(0, 3) == 0);
  assign tx_full = full_rand ? full_rnd_bit : full_force;

  uart_link_ctrl dut (
    .clk_i(clk), .rst_ni(rst_n), .char_req_i(char_req), .char_data_i(char_data),
    .char_ack_o(char_ack), .over_req_i(over_req), .tx_full_i(tx_full),
    .wr_uart_o(wr_uart), .w_data_o(w_data), .rx_empty_i(rx_empty), .r_data_i(r_data),
    .rd_uart_o(rd_uart), .rx_char_o(rx_char), .rx_char_valid_o(rx_char_valid),
    .remote_over_o(remote_over), .frame_err_o(frame_err), .tx_busy_o(tx_busy)
  );

  logic [7:0] tx_q[$];  // expected TX bytes in order
  logic [9:0] rx_q[$];  // expected RX events {kind, data}: 0 char, 1 err, 2 over
  int n_cmp = 0, n_bad = 0, n_ack = 0, ack_target = 0;
  bit model_ro = 1'b0;

  function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pop_ev(logic [1:0] kind, logic [7:0] data);
    logic [9:0] ev;
    if (rx_q.size() == 0) begin
      n_cmp++;
      n_bad++;
      $display("FAIL rx_unexpected: event kind %0d data %0h, none expected", kind, data);
    end else begin
      ev = rx_q.pop_front();
      chk("rx_kind", kind, ev[9:8]);
      if (kind == 2'd0) chk("rx_char", data, ev[7:0]);
    end
  endtask

  task automatic monitor();
    logic prev_ro = 1'b0;
    logic [7:0] eb;
    forever begin
      @(negedge clk);
      chk("rd_uart", rd_uart, rst_n & ~rx_empty);
      if (!tx_busy) chk("w_data_idle", w_data, 8'h00);
      if (char_ack) n_ack++;
      if (wr_uart) begin
        chk("wr_while_full", tx_full, 0);
        if (tx_q.size() == 0) begin
          n_cmp++;
          n_bad++;
          $display("FAIL tx_unexpected: wrote %h, no byte expected", w_data);
        end else begin
          eb = tx_q.pop_front();
          chk("tx_byte", w_data, eb);
        end
      end
      if (frame_err) pop_ev(2'd1, 8'h00);
      if (rx_char_valid) pop_ev(2'd0, rx_char);
      if (remote_over && !prev_ro) pop_ev(2'd2, 8'h00);
      prev_ro = remote_over;
    end
  endtask

  task automatic wait_ack();
    int i = 0;
    while (n_ack < ack_target && i < 200) begin
      @(negedge clk);
      i++;
    end
    chk("ack_seen", n_ack >= ack_target, 1);
    tick();
    char_req = 1'b0;
  endtask

  task automatic wait_idle();
    int i = 0;
    while ((tx_q.size() != 0 || tx_busy) && i < 300) begin
      @(negedge clk);
      i++;
    end
    chk("tx_drain", (tx_q.size() == 0) && !tx_busy, 1);
    chk("ack_count", n_ack, ack_target);
    tick();
  endtask

  // t: 0 char, 1 over, 2 char+over together, 3 over then char, 4 char+over then over again
  task automatic tx_txn(int t);
    logic [7:0] d = 8'($urandom);
    case (t)
      0: begin
        tx_q.push_back(TC); tx_q.push_back(d); ack_target++;
        char_data = d; char_req = 1'b1;
        wait_ack();
      end
      1: begin
        tx_q.push_back(TO); tx_q.push_back(OP);
        over_req = 1'b1; tick(); over_req = 1'b0;
      end
      2: begin
        tx_q.push_back(TC); tx_q.push_back(d); tx_q.push_back(TO); tx_q.push_back(OP);
        ack_target++;
        char_data = d; char_req = 1'b1; over_req = 1'b1;
        tick(); over_req = 1'b0;
        wait_ack();
      end
      3: begin
        tx_q.push_back(TO); tx_q.push_back(OP); tx_q.push_back(TC); tx_q.push_back(d);
        ack_target++;
        over_req = 1'b1; tick(); over_req = 1'b0;
        char_data = d; char_req = 1'b1;
        wait_ack();
      end
      default: begin
        tx_q.push_back(TC); tx_q.push_back(d); tx_q.push_back(TO); tx_q.push_back(OP);
        ack_target++;
        char_data = d; char_req = 1'b1; over_req = 1'b1;
        tick(); tick(); over_req = 1'b0;
        wait_ack();
      end
    endcase
    wait_idle();
  endtask

  task automatic rx_send(logic [7:0] b);
    repeat ($urandom_range(0, 2)) begin
      rx_empty = 1'b1; r_data = 8'($urandom); tick();
    end
    rx_empty = 1'b0; r_data = b; tick();
    rx_empty = 1'b1;
  endtask

  task automatic rx_random();
    logic [7:0] b;
    int i = 0;
    rx_q.push_back({2'd1, 8'h00}); rx_q.push_back({2'd0, 8'h5A}); rx_q.push_back({2'd2, 8'h00});
    model_ro = 1'b1;
    rx_send(8'h7E); rx_send(TC); rx_send(8'h5A); rx_send(TO); rx_send(8'h00);
    repeat (40) begin
      case ($urandom_range(0, 2))
        0: begin
          do b = 8'($urandom); while (b == TC || b == TO);
          rx_q.push_back({2'd1, 8'h00});
          rx_send(b);
        end
        1: begin
          b = 8'($urandom);
          rx_q.push_back({2'd0, b});
          rx_send(TC); rx_send(b);
        end
        default: begin
          rx_send(TO); rx_send(8'($urandom));
        end
      endcase
    end
    while (rx_q.size() != 0 && i < 20) begin
      tick();
      i++;
    end
    chk("rx_drain", rx_q.size(), 0);
    chk("remote_over_sticky", remote_over, model_ro);
  endtask

  task automatic tx_random();
    repeat (30) tx_txn($urandom_range(0, 4));
  endtask

  initial begin
    rst_n = 1'b0; char_req = 1'b1; char_data = 8'h33; over_req = 1'b1;
    full_rand = 1'b0; full_force = 1'b0; rx_empty = 1'b0; r_data = TC;
    fork monitor(); join_none
    #12;
    chk("rst_wr", wr_uart, 0);      chk("rst_wdata", w_data, 8'h00);
    chk("rst_rd", rd_uart, 0);      chk("rst_ack", char_ack, 0);
    chk("rst_busy", tx_busy, 0);    chk("rst_rxchar", rx_char, 8'h00);
    chk("rst_rxv", rx_char_valid, 0); chk("rst_ro", remote_over, 0);
    chk("rst_ferr", frame_err, 0);
    char_req = 1'b0; over_req = 1'b0; rx_empty = 1'b1;
    tick(); rst_n = 1'b1; tick();

    // Single character frame with no backpressure.
    tx_q.push_back(TC); tx_q.push_back(8'h41); ack_target++;
    char_data = 8'h41; char_req = 1'b1;
    @(negedge clk); chk("a0_ack", char_ack, 0); chk("a0_busy", tx_busy, 0);
    @(negedge clk); chk("a1_ack", char_ack, 1); chk("a1_wr", wr_uart, 1); chk("a1_busy", tx_busy, 1);
    tick(); char_req = 1'b0;
    @(negedge clk); chk("a2_ack", char_ack, 0); chk("a2_wr", wr_uart, 1); chk("a2_busy", tx_busy, 1);
    @(negedge clk); chk("a3_busy", tx_busy, 0); chk("a3_wr", wr_uart, 0);
    tick();

    // Five full cycles while the payload is pending.
    tx_q.push_back(TC); tx_q.push_back(8'h5A); ack_target++;
    char_data = 8'h5A; char_req = 1'b1;
    @(negedge clk);
    @(negedge clk); chk("b1_wr", wr_uart, 1);
    tick(); char_req = 1'b0; full_force = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk); chk("b_stall_wr", wr_uart, 0); chk("b_stall_busy", tx_busy, 1);
      chk("b_stall_data", w_data, 8'h5A);
      if (i < 4) tick();
    end
    tick(); full_force = 1'b0;
    @(negedge clk); chk("b_resume_wr", wr_uart, 1); chk("b_resume_data", w_data, 8'h5A);
    @(negedge clk); chk("b_done_busy", tx_busy, 0);
    chk("b_ack_count", n_ack, ack_target);
    tick();

    tx_txn(2);

    full_rand = 1'b1;
    fork
      tx_random();
      rx_random();
    join
    full_rand = 1'b0;
    wait_idle();

    // Reset during the payload cycle drops the frame.
    tx_q.push_back(TC); ack_target++;
    char_data = 8'h77; char_req = 1'b1;
    @(negedge clk);
    @(negedge clk);
    tick(); char_req = 1'b0;
    rst_n = 1'b0; rx_empty = 1'b0; r_data = TC;
    #1;
    chk("r_wr", wr_uart, 0); chk("r_busy", tx_busy, 0); chk("r_wdata", w_data, 8'h00);
    chk("r_rd", rd_uart, 0); chk("r_ro", remote_over, 0); chk("r_rxchar", rx_char, 8'h00);
    tick(); tick(); rx_empty = 1'b1;
    tick(); rst_n = 1'b1;
    repeat (10) tick();
    chk("r_no_resend", tx_q.size(), 0);
    chk("r_idle", tx_busy, 0);
    chk("r_ack_count", n_ack, ack_target);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
